// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, followed by one sign-correction cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       md_op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [1:0]       dbg_state
);

  // Handshake: a request transfers on a rising edge with valid_i & ready_o, a result
  // transfers on a rising edge with valid_o & ready_i; flush_i overrides both transfers.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state;
  state_e             state_next;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   result_q;

  logic             is_div;
  logic             a_signed;
  logic             b_signed;
  logic             sa;
  logic             sb;
  logic             b_zero;
  logic             div_ovf;
  logic             fast;
  logic             neg_in;
  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] fast_val;

  // Request decode, evaluated on the raw inputs in the accept cycle.
  always_comb begin
    is_div   = md_op_i[2];
    a_signed = (md_op_i == 3'd1) || (md_op_i == 3'd2) || (md_op_i == 3'd4) || (md_op_i == 3'd6);
    b_signed = (md_op_i == 3'd1) || (md_op_i == 3'd4) || (md_op_i == 3'd6);
    sa       = a_signed & operand_a_i[WIDTH-1];
    sb       = b_signed & operand_b_i[WIDTH-1];
    a_mag    = sa ? (~operand_a_i + 1'b1) : operand_a_i;
    b_mag    = sb ? (~operand_b_i + 1'b1) : operand_b_i;
    b_zero   = (operand_b_i == '0);
    div_ovf  = is_div & b_signed & (operand_a_i == MOST_NEG) & (operand_b_i == '1);
    fast     = is_div & (b_zero | div_ovf);
    if (b_zero) begin
      fast_val = md_op_i[1] ? operand_a_i : '1;
    end else begin
      fast_val = md_op_i[1] ? '0 : operand_a_i;
    end
    // The remainder takes the dividend's sign; everything else takes the XOR of signs.
    neg_in   = (md_op_i == 3'd6) ? sa : (sa ^ sb);
    accept   = (state == IDLE) & valid_i & ~flush_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (valid_i) state_next = fast ? DONE : BUSY;
        BUSY:    if (cnt_q == CNT_ONE) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    if (ready_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state)
      IDLE:    ready_o = 1'b1;
      DONE:    valid_o = 1'b1;
      default: ;
    endcase
  end

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_ext;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  // One iteration. acc_q holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {add_sum, acc_q[WIDTH-1:1]};
    // Shifted remainder keeps its carry-out so the compare stays exact.
    rem_ext  = acc_q[2*WIDTH-1:WIDTH-1];
    sub_diff = rem_ext - {1'b0, opnd_q};
    if (sub_diff[WIDTH]) begin
      div_next = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mul_sel;
  logic [WIDTH-1:0]   div_sel;
  logic [WIDTH-1:0]   fix_val;

  always_comb begin
    prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
    mul_sel = (op_q == 3'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    div_sel = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    if (neg_q) begin
      div_sel = ~div_sel + 1'b1;
    end
    fix_val = op_q[2] ? div_sel : mul_sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= md_op_i;
      neg_q <= neg_in;
      cnt_q <= CNT_INIT;
      if (is_div) begin
        acc_q  <= {{WIDTH{1'b0}}, a_mag};
        opnd_q <= b_mag;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, b_mag};
        opnd_q <= a_mag;
      end
      if (fast) begin
        result_q <= fast_val;
      end
    end else if (state == BUSY) begin
      acc_q <= op_q[2] ? div_next : mul_next;
      cnt_q <= cnt_q - CNT_ONE;
    end else if (state == FIX) begin
      result_q <= fix_val;
    end
  end

  assign result_o  = result_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M cases, randomized operations,
// backpressure, flush and asynchronous reset abort.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;
  localparam int LAT_NORMAL = W + 2;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         valid_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         ready_i = 1'b0;
  logic [2:0]   md_op_i = '0;
  logic [W-1:0] operand_a_i = '0;
  logic [W-1:0] operand_b_i = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] result_o;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 2;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .md_op_i    (md_op_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .dbg_state  (dbg_state)
  );

  // Clock, cycle counter and consumer-ready driver.
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0:       ready_i = ($urandom_range(0, 3) != 0);
        1:       ready_i = 1'b0;
        default: ready_i = 1'b1;
      endcase
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model written from the RV32M definitions with plain wide arithmetic.
  function automatic logic [W-1:0] model_res(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    logic [2*W-1:0] p;
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ea = (op == 3'd1 || op == 3'd2) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = (op == 3'd1) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    case (op)
      3'd0: return p[W-1:0];
      3'd1, 3'd2, 3'd3: return p[2*W-1:W];
      3'd4: begin
        if (b == '0) return '1;
        if (a == MIN_NEG && b == '1) return a;
        return W'(sa / sb);
      end
      3'd5: begin
        if (b == '0) return '1;
        return a / b;
      end
      3'd6: begin
        if (b == '0) return a;
        if (a == MIN_NEG && b == '1) return '0;
        return W'(sa % sb);
      end
      default: begin
        if (b == '0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    if (op[2] && (b == '0 || (!op[0] && a == MIN_NEG && b == '1))) return 1;
    return LAT_NORMAL;
  endfunction

  // Driver: waits for ready_o, presents one request for one edge, then scrambles inputs.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat, input bit expect_res);
    int guard = 0;
    @(negedge clk_i);
    while (!ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout ready_o=%b expected=1", ready_o);
      return;
    end
    valid_i = 1'b1;
    md_op_i = op;
    operand_a_i = a;
    operand_b_i = b;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    md_op_i = 3'($urandom_range(0, 7));
    operand_a_i = $urandom();
    operand_b_i = $urandom();
    if (expect_res) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
  endtask

  task automatic issue_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b, model_res(op, a, b), model_lat(op, a, b), 1'b1);
  endtask

  // Monitor / scoreboard: compares each new result and checks hold behaviour while stalled.
  logic         in_res = 1'b0;
  logic [W-1:0] held = '0;
  logic [W-1:0] mon_exp;
  int           mon_lat;
  int           mon_acc;

  always @(negedge clk_i) begin
    if (rst_ni && valid_o) begin
      if (!in_res) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid result=%h expected no result", result_o);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_lat = lat_q.pop_front();
          mon_acc = acc_q.pop_front();
          check("result", result_o, mon_exp);
          check("latency", W'(cyc - mon_acc + 1), W'(mon_lat));
        end
        held = result_o;
        in_res = 1'b1;
      end else begin
        check("hold_stable", result_o, held);
        check("ready_low_in_done", W'(ready_o), W'(0));
      end
      if (ready_i) in_res = 1'b0;
    end else begin
      in_res = 1'b0;
    end
  end

  task automatic wait_quiet(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           guard;

    repeat (3) @(negedge clk_i);
    check("reset_ready", W'(ready_o), W'(1));
    check("reset_valid", W'(valid_o), W'(0));
    check("reset_result", result_o, '0);
    check("reset_state", W'(dbg_state), W'(0));
    rst_ni = 1'b1;

    // Directed cases with hand-derived expectations.
    rdy_mode = 2;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
    issue(3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 34, 1'b1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1);
    issue(3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    issue(3'd7, 32'd100, 32'd7, 32'd2, 34, 1'b1);
    issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    issue(3'd6, 32'd5, 32'd0, 32'd5, 1, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
    issue(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b1);

    // Randomized operations with random consumer stalls.
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin a = $urandom(); b = '0; end
        1: begin a = MIN_NEG; b = '1; end
        2: begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(1, 15)); end
        3: begin a = $urandom(); b = ~W'($urandom_range(0, 8)); end
        default: begin a = $urandom(); b = $urandom(); end
      endcase
      issue_model(op, a, b);
    end

    // Backpressure: stall the result, push ignored requests, then release.
    rdy_mode = 2;
    wait_quiet(80);
    rdy_mode = 1;
    wait_quiet(2);
    issue_model(3'd5, 32'd1000, 32'd9);
    guard = 0;
    while (!valid_o && guard < 60) begin
      @(negedge clk_i);
      guard++;
    end
    check("bp_valid_seen", W'(valid_o), W'(1));
    repeat (10) begin
      @(negedge clk_i);
      valid_i = 1'b1;
      md_op_i = 3'($urandom_range(0, 7));
      operand_a_i = $urandom();
      operand_b_i = $urandom();
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    rdy_mode = 2;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check("bp_release_ready", W'(ready_o), W'(1));
    check("bp_release_valid", W'(valid_o), W'(0));

    // Flush in the middle of an iterative operation.
    issue(3'd0, $urandom(), $urandom(), '0, 0, 1'b0);
    wait_quiet(4);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_busy_ready", W'(ready_o), W'(1));
    check("flush_busy_state", W'(dbg_state), W'(0));
    wait_quiet(40);

    // Flush beats an accept in the same cycle.
    valid_i = 1'b1;
    flush_i = 1'b1;
    md_op_i = 3'd5;
    operand_a_i = 32'd9;
    operand_b_i = 32'd0;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_accept_ready", W'(ready_o), W'(1));
    check("flush_accept_valid", W'(valid_o), W'(0));
    wait_quiet(10);

    // Asynchronous reset in the middle of an operation.
    issue(3'd4, $urandom(), 32'd3, '0, 0, 1'b0);
    wait_quiet(10);
    rst_ni = 1'b0;
    #1;
    check("rst_abort_ready", W'(ready_o), W'(1));
    check("rst_abort_valid", W'(valid_o), W'(0));
    check("rst_abort_result", result_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_quiet(40);
    issue(3'd0, 32'd3, 32'd4, 32'd12, 34, 1'b1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk_i);
      guard++;
    end
    wait_quiet(5);
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit implementing the RV32M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Generalised in width, and sequential rather than combinational like the single-cycle ALU.
- Sits beside the ALU in the execute stage. Valid/ready handshakes on both request and result sides.
- One radix-2 step per cycle on operand magnitudes, followed by a sign-correction cycle. Special cases take a fast path.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request.
- md_op_i  input  3  operation, equal to RV funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a_i  input  WIDTH  rs1 (multiplicand / dividend).
- operand_b_i  input  WIDTH  rs2 (multiplier / divisor).
- flush_i  input  1  abort any in-flight operation.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- result_o  output  WIDTH  result; held stable while valid_o=1 and ready_i=0.

Behaviour:
- Clocking and reset:
  - One clock, clk_i.
  - rst_ni is asynchronous and active-low.
  - In reset: state=IDLE, ready_o=1, valid_o=0, result_o=0, all internal registers 0.
- States: IDLE, BUSY, FIX, DONE.
  - ready_o=1 only in IDLE.
  - valid_o=1 only in DONE.
- Accept:
  - A request is accepted at a rising edge where valid_i & ready_o.
  - Operands and op are captured; inputs are ignored afterwards.
- Signedness:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - Negative signed operands are replaced by their two's-complement magnitude at capture.
  - neg_res = sa^sb for multiply and DIV. neg_res = sa for REM.
- Fast path, decided at accept: IDLE->DONE, so valid_o is high 1 edge after accept.
  - DIV/DIVU with b=0: result all ones.
  - REM/REMU with b=0: result = a.
  - DIV with a=most-negative and b=-1: result = a.
  - REM with a=most-negative and b=-1: result = 0.
- Normal path: IDLE->BUSY, with counter=WIDTH.
  - Multiply (shift-add): 2*WIDTH accumulator. Each cycle, if multiplier LSB=1, add the multiplicand to the upper half, then shift right 1 including the carry.
  - Divide (restoring): each cycle, shift {rem,quot} left 1. If rem >= divisor, subtract and set quot LSB.
  - Counter decrements every BUSY cycle. At counter=1 the next state is FIX.
- FIX, one cycle: conditional two's-complement negate of the selected result, then ->DONE.
  - MUL selects the product low half.
  - MULH, MULHSU and MULHU select the product high half, after negating the full 2*WIDTH product when neg_res.
  - DIV/DIVU select the quotient.
  - REM/REMU select the remainder.
- Normal-path latency: valid_o rises WIDTH+2 edges after the accept edge.
- DONE:
  - result_o and valid_o are held until ready_i=1.
  - At the edge where valid_o & ready_i, next state is IDLE and ready_o returns to 1.
  - There is no same-cycle back-to-back issue: the next accept is earliest one cycle after the handshake.
- flush_i:
  - In any state, forces IDLE at the next edge with valid_o=0.
  - flush_i has priority over a handshake, and over an accept in the same cycle (no accept occurs).
- Reset mid-operation: immediate abort to reset values; no result is produced.
- Arithmetic:
  - All results wrap modulo 2^WIDTH.
  - Internal divider subtract is WIDTH+1 bits to preserve the borrow.
- Unknown op: not possible, since md_op_i is fully decoded over 3 bits.

Test Plan (WIDTH=32):
- MUL a=7, b=-3 (0xFFFFFFFD) -> after 34 edges, result_o=0xFFFFFFEB. MULHU with the same operands -> 0x00000006.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU a=100, b=7 -> 14. REMU with the same operands -> 2. Each takes 34-edge latency.
- DIVU a=5, b=0 -> valid_o 1 edge after accept, 0xFFFFFFFF. REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000. REM with the same operands -> 0.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o -> result_o stable, ready_o=0, new valid_i ignored. Raise ready_i -> IDLE next edge and ready_o=1.
- flush_i during BUSY cycle 5, and separately assert rst_ni=0 mid-BUSY -> IDLE, valid_o never asserted. A following MUL 3x4 -> 12.
